// File: rtl/inst_fetch.sv
// Instruction issuer: walks pc through a 1-cycle-latency instruction memory and hands words to control via valid/ready.
// Build option: define INST_COUNT_EN to include the handed-over instruction counter (inst_count); otherwise it reads 0.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read request to imem at pc
// WAIT  | imem_data valid, capture into inst
// ISSUE | inst offered, waiting for inst_ready
// HALT  | HLT handed over, waiting for restart
module inst_fetch #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       inst_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [2:0]        OP_HLT = 3'b101;
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  state_t state, state_next;
  logic   handshake;
  logic   is_hlt;
  logic   restart;

  assign handshake = (state == ISSUE) && inst_ready;
  assign is_hlt    = (inst[31:29] == OP_HLT);
  assign restart   = (state == HALT) && start;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = WAIT;
      WAIT:    state_next = ISSUE;
      ISSUE:   if (inst_ready) state_next = is_hlt ? HALT : FETCH;
      HALT:    if (start) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pc    <= PC_RST;
      inst  <= 32'd0;
    end else begin
      state <= state_next;
      if (state == WAIT) inst <= imem_data;
      if (handshake && !is_hlt) pc <= pc + 1'b1;
      else if (restart)         pc <= PC_RST;
    end
  end

  assign imem_en    = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == ISSUE);
  assign busy       = (state == FETCH) || (state == WAIT) || (state == ISSUE);
  assign halted     = (state == HALT);

`ifdef INST_COUNT_EN
  logic [31:0] count;

  always_ff @(posedge CLK) begin
    if (RST || restart) count <= 32'd0;
    else if (handshake) count <= count + 32'd1;
  end

  assign inst_count = count;
`else
  assign inst_count = 32'd0;
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction issuer on the producing side of the 32-bit instruction interface consumed by the control unit.
- Walks a program counter through instruction memory and captures each fetched word.
- Presents each word to the control unit with a valid/ready handshake.
- Stops after handing over an HLT instruction.
- Sits between the instruction memory (synchronous read, 1-cycle latency) and the control unit.

Parameters:
- ADDR_W, 8: width of the program counter and instruction-memory address; program depth is 2^ADDR_W words.
- RESET_PC, 0: PC value loaded on reset and on restart.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  begin or restart fetching; one-cycle pulse
- imem_en  output  1  instruction-memory read enable
- imem_addr  output  ADDR_W  instruction-memory read address (equals pc)
- imem_data  input  32  read data, valid the cycle after imem_en
- inst  output  32  instruction word offered to control
- inst_valid  output  1  inst holds an unconsumed instruction
- inst_ready  input  1  control accepts inst this cycle
- pc  output  ADDR_W  address of the current/next instruction
- busy  output  1  high in FETCH, WAIT, ISSUE
- halted  output  1  HLT has been handed over
- inst_count  output  32  handed-over instruction count (see Optional Feature)

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high.
- RST reset values, on the edge where RST is high and overriding all other inputs, including mid-fetch and mid-handshake:
  - state=IDLE, pc=RESET_PC, inst=0
  - inst_valid=0, imem_en=0, busy=0, halted=0, inst_count=0
- Instruction fields: opcode=inst[31:29]. HLT opcode is 3'b101. No other field is interpreted here.
- States: IDLE, FETCH, WAIT, ISSUE, HALT. All outputs are decoded from registered state; there is no combinational path from input to output.
- IDLE:
  - imem_en=0.
  - start=1 -> FETCH.
- FETCH:
  - imem_en=1, imem_addr=pc.
  - Next state WAIT unconditionally.
- WAIT:
  - imem_en=0; imem_data is valid.
  - On the edge: inst<=imem_data; next state ISSUE.
- ISSUE:
  - inst_valid=1. inst is held stable until the handshake.
  - inst_valid never drops without inst_ready.
  - On an edge with inst_ready=1:
    - If inst[31:29]==3'b101: next state HALT; pc is unchanged (it points at the HLT).
    - Otherwise: pc<=pc+1; next state FETCH.
  - inst_ready=0: stay in ISSUE.
- HALT:
  - halted=1, busy=0, inst_valid=0.
  - start=1 -> pc<=RESET_PC, halted<=0, next state FETCH.
- Latency: start sampled at edge k gives FETCH during cycle k+1, WAIT during k+2, inst_valid=1 during k+3.
- Throughput: with inst_ready tied high, one instruction is handed over every 3 cycles.
- start is ignored in FETCH, WAIT and ISSUE.
- PC wrap: pc at 2^ADDR_W-1 with a non-HLT handshake wraps to 0 and continues. No flag is raised.
- inst_ready while inst_valid=0 has no effect.

Optional Feature:
- Macro INST_COUNT_EN.
- Defined: inst_count increments by 1 (mod 2^32) on every handshake, including the HLT handshake.
  - Cleared by RST and on restart from HALT.
  - Holds its value in HALT and IDLE.
- Undefined: inst_count is tied to 32'd0 and no counter register is built.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then 5 cycles with start=0 -> imem_en=0, inst_valid=0, pc=0, busy=0, halted=0 throughout.
- Straight-line program: imem[0]=32'h0000_0000 (ADD), imem[1]=32'h2000_0000 (SUB), imem[2]=32'hA000_0000 (HLT); start pulse at edge k, inst_ready=1:
  - inst_valid rises in cycle k+3 with inst=32'h0000_0000.
  - Words are handed over at k+3, k+6, k+9.
  - Then halted=1, pc=2.
  - inst_count=3 with INST_COUNT_EN, 0 without.
- Backpressure: hold inst_ready=0 for 4 cycles in ISSUE -> inst and inst_valid are stable, imem_en=0 and pc is unchanged. Raise inst_ready -> exactly one handshake, then FETCH of pc+1.
- Wrap: ADDR_W=2, imem[3]=ADD, imem[0]=HLT, RESET_PC=3 -> after imem[3] is handed over, imem_addr=0, the next inst is HLT and halted=1 with pc=0.
- Reset mid-operation: assert RST during ISSUE with inst_valid=1 -> next cycle inst_valid=0, inst=0, pc=RESET_PC, state IDLE. A subsequent start refetches from RESET_PC.
- Restart after halt: in HALT, pulse start -> halted=0 the next cycle, imem_en=1 with imem_addr=RESET_PC, and inst_count is back to 0. Starts pulsed in ISSUE are ignored.
